// File: rtl/e203_irq_stim_gen.sv
// e203_irq_stim_gen: LFSR-timed ext/sft/tmr interrupt stimulus driven by commit PCs
module e203_irq_stim_gen #(
  parameter int PC_W = 32,
  parameter int WAIT_W = 10,
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001,
  parameter logic [31:0] STOP_CNT = 32'd32,
  parameter logic [PC_W-1:0] PC_ARM = 32'h8000_015C,
  parameter logic [PC_W-1:0] PC_TOHOST = 32'h8000_0086,
  parameter logic [PC_W-1:0] PC_EXT_ACK = 32'h8000_00A6,
  parameter logic [PC_W-1:0] PC_SFT_ACK = 32'h8000_00BE,
  parameter logic [PC_W-1:0] PC_TMR_ACK = 32'h8000_00D6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            cmt_valid,
  input  logic [PC_W-1:0] cmt_pc,
  output logic            ext_irq,
  output logic            sft_irq,
  output logic            tmr_irq,
  output logic            armed,
  output logic [31:0]     tohost_cnt,
  output logic            stopped,
  output logic            quiet,
  output logic [15:0]     ext_cnt,
  output logic [15:0]     sft_cnt,
  output logic [15:0]     tmr_cnt
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_ASSERT, S_DONE} st_t;
  localparam logic [31:0] TAPS = 32'h8020_0003;
  st_t st [3];
  st_t nst [3];
  logic [WAIT_W:0] wcnt [3];
  logic [WAIT_W-1:0] slice [3];
  logic [2:0][15:0] cnt;
  logic [31:0] lfsr;
  logic [2:0] irq, hit_ack, take;
  logic hit_arm, hit_toh;
  assign hit_arm = cmt_valid & (cmt_pc == PC_ARM);
  assign hit_toh = cmt_valid & (cmt_pc == PC_TOHOST);
  assign hit_ack = {cmt_valid & (cmt_pc == PC_TMR_ACK), cmt_valid & (cmt_pc == PC_SFT_ACK), cmt_valid & (cmt_pc == PC_EXT_ACK)};
  assign stopped = tohost_cnt > STOP_CNT;
  assign quiet = stopped & ~|irq;
  assign {tmr_irq, sft_irq, ext_irq} = irq;
  assign {tmr_cnt, sft_cnt, ext_cnt} = cnt;
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      slice[k] = lfsr[k*WAIT_W +: WAIT_W];
      take[k] = enable & (st[k] == S_ASSERT) & hit_ack[k];
      case (st[k])
        S_IDLE:   nst[k] = armed ? S_LOAD : S_IDLE;
        S_LOAD:   nst[k] = S_WAIT;
        S_WAIT:   nst[k] = wcnt[k] == (WAIT_W+1)'(1) ? S_ASSERT : S_WAIT;
        S_ASSERT: nst[k] = hit_ack[k] ? (stopped ? S_DONE : S_LOAD) : S_ASSERT;
        default:  nst[k] = S_DONE;
      endcase
      if (!enable) nst[k] = S_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
      armed <= 1'b0;
      tohost_cnt <= '0;
      irq <= '0;
      cnt <= '0;
      for (int k = 0; k < 3; k++) begin
        st[k] <= S_IDLE;
        wcnt[k] <= '0;
      end
    end else begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
      armed <= enable & (armed | hit_arm);
      tohost_cnt <= tohost_cnt + 32'(hit_toh & ~&tohost_cnt);
      for (int k = 0; k < 3; k++) begin
        st[k] <= nst[k];
        irq[k] <= nst[k] == S_ASSERT;
        cnt[k] <= cnt[k] + 16'(take[k]);
        wcnt[k] <= st[k] == S_LOAD ? {1'b0, slice[k]} + (WAIT_W+1)'(1) : wcnt[k] - (WAIT_W+1)'(st[k] == S_WAIT);
      end
    end
  end
endmodule

// File: tb/tb_e203_irq_stim_gen.sv
// tb_e203_irq_stim_gen: vector table, directed corners and a timestamp scoreboard for e203_irq_stim_gen
module tb_e203_irq_stim_gen;
  localparam logic [31:0] ARM = 32'h8000_015C;
  localparam logic [31:0] TOH = 32'h8000_0086;
  localparam logic [31:0] ACK [3] = '{32'h8000_00A6, 32'h8000_00BE, 32'h8000_00D6};
  typedef struct {
    logic en;
    logic v;
    logic [31:0] pc;
    logic exp_armed;
    logic [31:0] exp_toh;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, cmt_valid = 1'b0;
  logic [31:0] cmt_pc = '0;
  logic ext_irq, sft_irq, tmr_irq, armed, stopped, quiet;
  logic [31:0] tohost_cnt;
  logic [15:0] ext_cnt, sft_cnt, tmr_cnt;
  logic [2:0] irqs;
  int total = 0, bad = 0;
  bit chk_en = 1'b0, preload = 1'b0;
  logic [31:0] preload_val = '0;
  int unsigned cyc = 0;
  logic [31:0] m_lfsr = 32'h1, m_toh = '0;
  bit m_armed = 1'b0;
  logic [2:0] m_wait = '0, m_high = '0, m_done = '0;
  logic [15:0] m_cnt [3] = '{16'd0, 16'd0, 16'd0};
  int unsigned m_due [3] = '{0, 0, 0};
  vec_t tbl [8];
  int unsigned a, n, r, ch;
  int unsigned rise [3];
  int unsigned exp_rise [3];
  logic [31:0] la;
  logic [15:0] saved;
  bit found, seen;

  assign irqs = {tmr_irq, sft_irq, ext_irq};
  always #5 clk = ~clk;

  e203_irq_stim_gen dut (
    .clk(clk), .rst(rst), .enable(enable), .cmt_valid(cmt_valid), .cmt_pc(cmt_pc),
    .ext_irq(ext_irq), .sft_irq(sft_irq), .tmr_irq(tmr_irq), .armed(armed),
    .tohost_cnt(tohost_cnt), .stopped(stopped), .quiet(quiet),
    .ext_cnt(ext_cnt), .sft_cnt(sft_cnt), .tmr_cnt(tmr_cnt)
  );

  function automatic logic [31:0] nx(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic int unsigned slc(input logic [31:0] v, input int k);
    return (v >> (10 * k)) & 32'h3FF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic step(input logic e, input logic v, input logic [31:0] pc);
    enable = e;
    cmt_valid = v;
    cmt_pc = pc;
    @(negedge clk);
  endtask

  // Reference: each channel keeps the cycle its IRQ is due to rise instead of a countdown.
  always @(posedge clk) begin
    logic [31:0] nl;
    bit stp;
    if (preload) m_toh = preload_val;
    if (rst) begin
      m_lfsr = 32'h1;
      m_toh = '0;
      m_armed = 1'b0;
      m_wait = '0;
      m_high = '0;
      m_done = '0;
      for (int k = 0; k < 3; k++) m_cnt[k] = '0;
    end else begin
      nl = nx(m_lfsr);
      stp = m_toh > 32;
      for (int k = 0; k < 3; k++) begin
        if (!enable) begin
          m_wait[k] = 1'b0;
          m_high[k] = 1'b0;
          m_done[k] = 1'b0;
        end else if (m_high[k]) begin
          if (cmt_valid && cmt_pc == ACK[k]) begin
            m_high[k] = 1'b0;
            m_cnt[k] = m_cnt[k] + 16'd1;
            if (stp) m_done[k] = 1'b1;
            else begin
              m_wait[k] = 1'b1;
              m_due[k] = cyc + 3 + slc(nl, k);
            end
          end
        end else if (m_wait[k]) begin
          if (cyc + 1 == m_due[k]) begin
            m_wait[k] = 1'b0;
            m_high[k] = 1'b1;
          end
        end else if (!m_done[k] && m_armed) begin
          m_wait[k] = 1'b1;
          m_due[k] = cyc + 3 + slc(nl, k);
        end
      end
      m_armed = enable && (m_armed || (cmt_valid && cmt_pc == ARM));
      if (cmt_valid && cmt_pc == TOH && m_toh != 32'hFFFF_FFFF) m_toh = m_toh + 1;
      m_lfsr = nl;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("sb_irqs", 32'(irqs), 32'(m_high));
      chk("sb_armed", 32'(armed), 32'(m_armed));
      chk("sb_tohost", tohost_cnt, m_toh);
      chk("sb_stopped", 32'(stopped), 32'(m_toh > 32));
      chk("sb_quiet", 32'(quiet), 32'((m_toh > 32) && m_high == 3'b000));
      chk("sb_ext_cnt", 32'(ext_cnt), 32'(m_cnt[0]));
      chk("sb_sft_cnt", 32'(sft_cnt), 32'(m_cnt[1]));
      chk("sb_tmr_cnt", 32'(tmr_cnt), 32'(m_cnt[2]));
    end
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, ARM, 1'b0, 32'd0};
    tbl[1] = '{1'b1, 1'b1, TOH, 1'b0, 32'd1};
    tbl[2] = '{1'b0, 1'b1, ARM, 1'b0, 32'd1};
    tbl[3] = '{1'b1, 1'b1, ARM + 32'd4, 1'b0, 32'd1};
    tbl[4] = '{1'b0, 1'b1, TOH, 1'b0, 32'd2};
    tbl[5] = '{1'b1, 1'b0, TOH, 1'b0, 32'd2};
    tbl[6] = '{1'b1, 1'b1, ARM, 1'b1, 32'd2};
    tbl[7] = '{1'b0, 1'b0, 32'd0, 1'b0, 32'd2};
    rst = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    rst = 1'b0;
    chk("rst_armed", 32'(armed), 0);
    chk("rst_irqs", 32'(irqs), 0);
    chk("rst_tohost", tohost_cnt, 0);
    chk("rst_cnts", {ext_cnt, sft_cnt | tmr_cnt}, 0);
    chk("rst_quiet", 32'(quiet), 0);
    chk_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].en, tbl[i].v, tbl[i].pc);
      chk($sformatf("vec%0d_armed", i), 32'(armed), 32'(tbl[i].exp_armed));
      chk($sformatf("vec%0d_tohost", i), tohost_cnt, tbl[i].exp_toh);
      chk($sformatf("vec%0d_irqs", i), 32'(irqs), 0);
    end
    rst = 1'b1;
    step(0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 500; i++) step(1, 1'($urandom), $urandom & 32'h7FFF_FFFF);
    chk("idle_armed", 32'(armed), 0);
    chk("idle_irqs", 32'(irqs), 0);
    a = cyc;
    la = m_lfsr;
    step(1, 1, ARM);
    chk("arm_next", 32'(armed), 1);
    for (int k = 0; k < 3; k++) begin
      rise[k] = 0;
      exp_rise[k] = a + 4 + slc(nx(nx(la)), k);
    end
    for (int i = 0; i < 1100; i++) begin
      step(1, 0, 0);
      for (int k = 0; k < 3; k++) if (irqs[k] && rise[k] == 0) rise[k] = cyc;
    end
    chk("ext_rise_cycle", rise[0], exp_rise[0]);
    chk("sft_rise_cycle", rise[1], exp_rise[1]);
    chk("tmr_rise_cycle", rise[2], exp_rise[2]);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, ACK[1]);
      chk("sft_hold_invalid", 32'(sft_irq), 1);
    end
    step(1, 1, ACK[1]);
    chk("sft_ack_low", 32'(sft_irq), 0);
    chk("sft_ack_cnt", 32'(sft_cnt), 1);
    chk("ext_still_high", 32'(ext_irq), 1);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 7);
      ch = $urandom_range(0, 2);
      if (r < 3) step(1, 1, ACK[ch]);
      else if (r == 3) step(1, 1, $urandom & 32'h7FFF_FFFF);
      else step(1, 0, r == 4 ? ACK[ch] : r == 5 ? ARM : r == 6 ? TOH : $urandom);
    end
    n = 0;
    while (!ext_irq && n < 2200) begin
      step(1, 0, 0);
      n++;
    end
    chk("ext_rise_bound", 32'(ext_irq), 1);
    saved = m_cnt[0];
    step(0, 0, 0);
    chk("dis_ext_low", 32'(ext_irq), 0);
    chk("dis_armed_low", 32'(armed), 0);
    chk("dis_ext_cnt_hold", 32'(ext_cnt), 32'(saved));
    step(1, 1, ARM);
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      if (m_wait[2] && m_due[2] > cyc + 40) found = 1'b1;
      else step(1, tmr_irq, ACK[2]);
    end
    chk("tmr_wait_found", 32'(found), 1);
    for (int i = 0; i < 32; i++) step(1, 1, TOH);
    chk("toh32_cnt", tohost_cnt, 32);
    chk("toh32_not_stopped", 32'(stopped), 0);
    step(1, 1, TOH);
    chk("toh33_cnt", tohost_cnt, 33);
    chk("toh33_stopped", 32'(stopped), 1);
    n = 0;
    while (!tmr_irq && n < 1100) begin
      step(1, 0, 0);
      n++;
    end
    chk("tmr_asserts_after_stop", 32'(tmr_irq), 1);
    saved = m_cnt[2];
    step(1, 1, ACK[2]);
    chk("tmr_ack_low", 32'(tmr_irq), 0);
    chk("tmr_ack_cnt", 32'(tmr_cnt), 32'(saved + 16'd1));
    seen = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      step(1, ext_irq | sft_irq, ext_irq ? ACK[0] : ACK[1]);
      seen |= tmr_irq;
    end
    chk("tmr_done_stays_low", 32'(seen), 0);
    chk("quiet_final", 32'(quiet), 1);
    rst = 1'b1;
    step(0, 0, 0);
    rst = 1'b0;
    step(1, 1, ARM);
    n = 0;
    while (irqs == 3'b000 && n < 1100) begin
      step(1, 0, 0);
      n++;
    end
    chk("rearm_any_irq", 32'(|irqs), 1);
    ch = ext_irq ? 0 : sft_irq ? 1 : 2;
    rst = 1'b1;
    step(1, 1, ACK[ch]);
    rst = 1'b0;
    chk("rst_mid_irqs", 32'(irqs), 0);
    chk("rst_mid_cnts", {ext_cnt, sft_cnt | tmr_cnt}, 0);
    #1 force dut.tohost_cnt = 32'hFFFF_FFFC;
    preload_val = 32'hFFFF_FFFC;
    preload = 1'b1;
    #1 release dut.tohost_cnt;
    step(1, 1, TOH);
    preload = 1'b0;
    chk("sat_fffd", tohost_cnt, 32'hFFFF_FFFD);
    step(1, 1, TOH);
    step(1, 1, TOH);
    chk("sat_ffff", tohost_cnt, 32'hFFFF_FFFF);
    step(1, 1, TOH);
    step(1, 1, TOH);
    chk("sat_no_wrap", tohost_cnt, 32'hFFFF_FFFF);
    chk("sat_stopped", 32'(stopped), 1);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
